// File: rtl/fc1_csr_ctrl_pkg.sv
// Shared types and constants for the FC1 per-channel CSR access controller.
package fc1_csr_ctrl_pkg;

    localparam int          CHAN_W        = 5;
    localparam logic [4:0]  BCAST_CHAN    = 5'd31;
    localparam logic [63:0] CSR_DEAD_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } csr_state_e;

endpackage

// File: rtl/fc1_csr_rd_mux.sv
// Combinational select of one channel's read data and read-valid by channel index.
module fc1_csr_rd_mux
    import fc1_csr_ctrl_pkg::*;
#(
    parameter int CHANNELS = 26
) (
    input  logic [CHAN_W-1:0]      ch,
    input  logic [CHANNELS*64-1:0] rd_data,
    input  logic [CHANNELS-1:0]    rd_data_v,
    output logic [63:0]            sel_data,
    output logic                   sel_v
);

    // Out-of-range indices select nothing, so an illegal channel never sees a valid.
    always_comb begin
        sel_data = '0;
        sel_v    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == CHAN_W'(i)) begin
                sel_data = rd_data[i*64 +: 64];
                sel_v    = rd_data_v[i];
            end
        end
    end

endmodule

// File: rtl/fc1_csr_chan_ctrl.sv
// Steers single CSR accesses to one FC1 channel (or broadcasts writes), collects read data with timeout.
// Optional feature: define FC1_CSR_BCAST_EN to enable write broadcast on channel index 31.
module fc1_csr_chan_ctrl
    import fc1_csr_ctrl_pkg::*;
#(
    parameter int CHANNELS       = 26,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   iCLK_100M,
    input  logic                   iRST_100M,
    input  logic                   iCSR_WR_EN,
    input  logic                   iCSR_RD_EN,
    input  logic [14:0]            iCSR_ADDR,
    input  logic [63:0]            iCSR_WR_DATA,
    output logic [63:0]            oCSR_RD_DATA,
    output logic                   oCSR_RD_DATA_V,
    output logic                   oCSR_ACK,
    output logic                   oCSR_BUSY,
    output logic [CHANNELS-1:0]    oCH_CSR_WR_EN,
    output logic [CHANNELS-1:0]    oCH_CSR_RD_EN,
    output logic [9:0]             oCH_CSR_ADDR,
    output logic [63:0]            oCH_CSR_WR_DATA,
    input  logic [CHANNELS*64-1:0] iCH_CSR_RD_DATA,
    input  logic [CHANNELS-1:0]    iCH_CSR_RD_DATA_V,
    output logic                   oTIMEOUT_ERR,
    output logic                   oDROP_ERR,
    output logic [4:0]             oERR_CHAN
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    csr_state_e        state;
    csr_state_e        next_state;
    logic [CHAN_W-1:0] ch;
    logic              is_read;
    logic [9:0]        reg_addr;
    logic [63:0]       wr_data;
    logic [63:0]       rd_data;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_err;
    logic              drop_err;
    logic [CHAN_W-1:0] err_chan;
    logic              chan_legal;
    logic              bcast;
    logic [63:0]       sel_data;
    logic              sel_v;
    logic              accept;
    logic              drop;

    assign chan_legal = (int'(ch) < CHANNELS);

`ifdef FC1_CSR_BCAST_EN
    assign bcast = (ch == BCAST_CHAN);
`else
    assign bcast = 1'b0;
`endif

    assign accept = (state == IDLE) && (iCSR_WR_EN || iCSR_RD_EN);
    // A collision in IDLE keeps the write; anything arriving while busy is lost.
    assign drop   = ((state == IDLE) && iCSR_WR_EN && iCSR_RD_EN) ||
                    ((state != IDLE) && (iCSR_WR_EN || iCSR_RD_EN));

    fc1_csr_rd_mux #(
        .CHANNELS (CHANNELS)
    ) u_rd_mux (
        .ch        (ch),
        .rd_data   (iCH_CSR_RD_DATA),
        .rd_data_v (iCH_CSR_RD_DATA_V),
        .sel_data  (sel_data),
        .sel_v     (sel_v)
    );

    always_ff @(posedge iCLK_100M) begin
        if (iRST_100M) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state     = state;
        oCSR_ACK       = 1'b0;
        oCSR_RD_DATA_V = 1'b0;
        oCSR_BUSY      = (state != IDLE);
        oCH_CSR_WR_EN  = '0;
        oCH_CSR_RD_EN  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            oCH_CSR_WR_EN[i] = (state == WR_ISSUE) && (bcast || (ch == CHAN_W'(i)));
            oCH_CSR_RD_EN[i] = (state == RD_ISSUE) && (ch == CHAN_W'(i));
        end
        case (state)
            IDLE: begin
                if (iCSR_WR_EN)      next_state = WR_ISSUE;
                else if (iCSR_RD_EN) next_state = RD_ISSUE;
            end
            WR_ISSUE: next_state = RESP;
            RD_ISSUE: next_state = chan_legal ? RD_WAIT : RESP;
            RD_WAIT: begin
                if (sel_v || (wait_cnt == CNT_LAST)) next_state = RESP;
            end
            RESP: begin
                oCSR_ACK       = 1'b1;
                oCSR_RD_DATA_V = is_read;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, read capture, wait counter and sticky error flags.
    always_ff @(posedge iCLK_100M) begin
        if (iRST_100M) begin
            ch          <= '0;
            is_read     <= 1'b0;
            reg_addr    <= '0;
            wr_data     <= '0;
            rd_data     <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            drop_err    <= 1'b0;
            err_chan    <= '0;
        end else begin
            if (drop) drop_err <= 1'b1;
            if (accept) begin
                ch       <= iCSR_ADDR[14:10];
                reg_addr <= iCSR_ADDR[9:0];
                wr_data  <= iCSR_WR_DATA;
                is_read  <= iCSR_RD_EN && !iCSR_WR_EN;
            end
            if (state == RD_ISSUE) begin
                wait_cnt <= '0;
                if (!chan_legal) rd_data <= CSR_DEAD_DATA;
            end
            // A valid in the final wait cycle beats the timeout.
            if (state == RD_WAIT) begin
                if (sel_v) begin
                    rd_data <= sel_data;
                end else if (wait_cnt == CNT_LAST) begin
                    rd_data     <= CSR_DEAD_DATA;
                    timeout_err <= 1'b1;
                    err_chan    <= ch;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

    assign oCSR_RD_DATA    = rd_data;
    assign oCH_CSR_ADDR    = reg_addr;
    assign oCH_CSR_WR_DATA = wr_data;
    assign oTIMEOUT_ERR    = timeout_err;
    assign oDROP_ERR       = drop_err;
    assign oERR_CHAN       = err_chan;

endmodule

// File: tb/tb_fc1_csr_chan_ctrl.sv
// Directed self-checking bench for fc1_csr_chan_ctrl (default CHANNELS=26, TIMEOUT_CYCLES=64).
module tb_fc1_csr_chan_ctrl;

    localparam int CHANNELS = 26;
    localparam int TIMEOUT  = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wr_en;
    logic                   rd_en;
    logic [14:0]            addr;
    logic [63:0]            wdata;
    logic [63:0]            rd_data;
    logic                   rd_data_v;
    logic                   ack;
    logic                   busy;
    logic [CHANNELS-1:0]    ch_wr_en;
    logic [CHANNELS-1:0]    ch_rd_en;
    logic [9:0]             ch_addr;
    logic [63:0]            ch_wdata;
    logic [CHANNELS*64-1:0] ch_rd_data;
    logic [CHANNELS-1:0]    ch_rd_data_v;
    logic                   timeout_err;
    logic                   drop_err;
    logic [4:0]             err_chan;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc1_csr_chan_ctrl #(
        .CHANNELS       (CHANNELS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .iCLK_100M         (clk),
        .iRST_100M         (rst),
        .iCSR_WR_EN        (wr_en),
        .iCSR_RD_EN        (rd_en),
        .iCSR_ADDR         (addr),
        .iCSR_WR_DATA      (wdata),
        .oCSR_RD_DATA      (rd_data),
        .oCSR_RD_DATA_V    (rd_data_v),
        .oCSR_ACK          (ack),
        .oCSR_BUSY         (busy),
        .oCH_CSR_WR_EN     (ch_wr_en),
        .oCH_CSR_RD_EN     (ch_rd_en),
        .oCH_CSR_ADDR      (ch_addr),
        .oCH_CSR_WR_DATA   (ch_wdata),
        .iCH_CSR_RD_DATA   (ch_rd_data),
        .iCH_CSR_RD_DATA_V (ch_rd_data_v),
        .oTIMEOUT_ERR      (timeout_err),
        .oDROP_ERR         (drop_err),
        .oERR_CHAN         (err_chan)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic rd, input logic [4:0] ch,
                                  input logic [9:0] reg_a, input logic [63:0] data);
        wr_en = wr;
        rd_en = rd;
        addr  = {ch, reg_a};
        wdata = data;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_busy"},   64'(busy), 64'd0);
        check_output({tag, "_ack"},    64'(ack), 64'd0);
        check_output({tag, "_rdv"},    64'(rd_data_v), 64'd0);
        check_output({tag, "_wr_en"},  64'(ch_wr_en), 64'd0);
        check_output({tag, "_rd_en"},  64'(ch_rd_en), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        ch_rd_data   = '0;
        ch_rd_data_v = '0;
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        tick(3);

        // Reset state
        check_idle_outputs("rst");
        check_output("rst_addr",    64'(ch_addr), 64'd0);
        check_output("rst_wdata",   ch_wdata, 64'd0);
        check_output("rst_rdata",   rd_data, 64'd0);
        check_output("rst_tmo",     64'(timeout_err), 64'd0);
        check_output("rst_drop",    64'(drop_err), 64'd0);
        check_output("rst_errchan", 64'(err_chan), 64'd0);
        rst = 1'b0;
        tick();

        // Write ch 3, addr 0x010, data 0x1234
        apply_stimulus(1'b1, 1'b0, 5'd3, 10'h010, 64'h1234);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        check_output("wr3_strobe", 64'(ch_wr_en), 64'h8);
        check_output("wr3_rd_en",  64'(ch_rd_en), 64'd0);
        check_output("wr3_busy1",  64'(busy), 64'd1);
        check_output("wr3_ack1",   64'(ack), 64'd0);
        check_output("wr3_addr",   64'(ch_addr), 64'h010);
        check_output("wr3_wdata",  ch_wdata, 64'h1234);
        tick();
        check_output("wr3_ack2",    64'(ack), 64'd1);
        check_output("wr3_busy2",   64'(busy), 64'd1);
        check_output("wr3_strobe2", 64'(ch_wr_en), 64'd0);
        check_output("wr3_rdv2",    64'(rd_data_v), 64'd0);
        tick();
        check_idle_outputs("wr3_done");
        check_output("wr3_addr_hold", 64'(ch_addr), 64'h010);

        // Read ch 25; ch 24 valid during wait is ignored; ch 25 valid at strobe+5
        apply_stimulus(1'b0, 1'b1, 5'd25, 10'h044, 64'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        check_output("rd25_strobe", 64'(ch_rd_en), 64'h1 << 25);
        check_output("rd25_wr_en",  64'(ch_wr_en), 64'd0);
        tick(2);
        ch_rd_data[24*64 +: 64] = 64'h5555;
        ch_rd_data_v[24]        = 1'b1;
        tick();
        ch_rd_data_v[24] = 1'b0;
        check_output("rd25_ch24_ack", 64'(ack), 64'd0);
        check_output("rd25_ch24_rdv", 64'(rd_data_v), 64'd0);
        tick(2);
        ch_rd_data[25*64 +: 64] = 64'hABCD;
        ch_rd_data_v[25]        = 1'b1;
        tick();
        ch_rd_data_v[25] = 1'b0;
        check_output("rd25_rdv",   64'(rd_data_v), 64'd1);
        check_output("rd25_ack",   64'(ack), 64'd1);
        check_output("rd25_rdata", rd_data, 64'hABCD);
        tick();
        check_idle_outputs("rd25_done");
        check_output("rd25_hold", rd_data, 64'hABCD);
        check_output("rd25_tmo",  64'(timeout_err), 64'd0);

        // Illegal read ch 28 -> DEAD at N+2, no strobe
        apply_stimulus(1'b0, 1'b1, 5'd28, 10'h001, 64'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        check_output("rd28_rd_en", 64'(ch_rd_en), 64'd0);
        check_output("rd28_ack1",  64'(ack), 64'd0);
        tick();
        check_output("rd28_rdv",   64'(rd_data_v), 64'd1);
        check_output("rd28_ack",   64'(ack), 64'd1);
        check_output("rd28_rdata", rd_data, 64'hDEAD_DEAD_DEAD_DEAD);
        check_output("rd28_tmo",   64'(timeout_err), 64'd0);
        tick();

        // Timeout read ch 7 -> DEAD at N+66
        apply_stimulus(1'b0, 1'b1, 5'd7, 10'h0FF, 64'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        check_output("rd7_strobe", 64'(ch_rd_en), 64'h80);
        tick(64);
        check_output("rd7_early_ack", 64'(ack), 64'd0);
        check_output("rd7_early_tmo", 64'(timeout_err), 64'd0);
        check_output("rd7_early_bsy", 64'(busy), 64'd1);
        tick();
        check_output("rd7_rdv",     64'(rd_data_v), 64'd1);
        check_output("rd7_ack",     64'(ack), 64'd1);
        check_output("rd7_rdata",   rd_data, 64'hDEAD_DEAD_DEAD_DEAD);
        check_output("rd7_tmo",     64'(timeout_err), 64'd1);
        check_output("rd7_errchan", 64'(err_chan), 64'd7);
        check_output("rd7_drop",    64'(drop_err), 64'd0);
        tick();
        check_idle_outputs("rd7_done");
        check_output("rd7_tmo_sticky", 64'(timeout_err), 64'd1);

        // Simultaneous WR+RD on ch 4: write wins, read dropped
        apply_stimulus(1'b1, 1'b1, 5'd4, 10'h004, 64'h4444);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        check_output("both_wr_en", 64'(ch_wr_en), 64'h10);
        check_output("both_rd_en", 64'(ch_rd_en), 64'd0);
        tick();
        check_output("both_ack",  64'(ack), 64'd1);
        check_output("both_rdv",  64'(rd_data_v), 64'd0);
        check_output("both_drop", 64'(drop_err), 64'd1);
        tick();
        check_output("both_rd_en2", 64'(ch_rd_en), 64'd0);
        check_output("both_busy2",  64'(busy), 64'd0);

        // Write to broadcast index 31
        apply_stimulus(1'b1, 1'b0, 5'd31, 10'h031, 64'h3131);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
`ifdef FC1_CSR_BCAST_EN
        check_output("bc_wr_en", 64'(ch_wr_en), 64'h3FF_FFFF);
`else
        check_output("bc_wr_en", 64'(ch_wr_en), 64'd0);
`endif
        tick();
        check_output("bc_ack",    64'(ack), 64'd1);
        check_output("bc_wr_en2", 64'(ch_wr_en), 64'd0);
        tick();

        // Reset while in RD_WAIT, then a late valid
        apply_stimulus(1'b0, 1'b1, 5'd10, 10'h100, 64'h0);
        tick(3);
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        check_output("mid_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        ch_rd_data[10*64 +: 64] = 64'h7777;
        ch_rd_data_v[10]        = 1'b1;
        check_idle_outputs("mid_rst");
        check_output("mid_rdata", rd_data, 64'd0);
        check_output("mid_tmo",   64'(timeout_err), 64'd0);
        check_output("mid_drop",  64'(drop_err), 64'd0);
        check_output("mid_addr",  64'(ch_addr), 64'd0);
        tick();
        ch_rd_data_v[10] = 1'b0;
        check_output("late_rdv",  64'(rd_data_v), 64'd0);
        check_output("late_ack",  64'(ack), 64'd0);
        check_output("late_busy", 64'(busy), 64'd0);
        tick();

        // Write ch 1, then a read arriving while busy is dropped
        apply_stimulus(1'b1, 1'b0, 5'd1, 10'h020, 64'hCAFE);
        tick();
        check_output("busy_wr_en", 64'(ch_wr_en), 64'h2);
        apply_stimulus(1'b0, 1'b1, 5'd2, 10'h022, 64'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 5'd0, 10'h0, 64'h0);
        check_output("busy_ack",   64'(ack), 64'd1);
        check_output("busy_rd_en", 64'(ch_rd_en), 64'd0);
        check_output("busy_drop",  64'(drop_err), 64'd1);
        check_output("busy_wdata", ch_wdata, 64'hCAFE);
        tick();
        check_idle_outputs("busy_done");
        check_output("busy_addr_hold", 64'(ch_addr), 64'h020);
        tick(2);
        check_output("busy_no_late_rd", 64'(ch_rd_en), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
